// File: rtl/mem_req_pkg.sv
// mem_req_pkg: shared state encoding and default widths for memory requesters
package mem_req_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 4;
  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;
endpackage

// File: rtl/mem_requester_if.sv
// mem_requester_if: client request/response and memory port bundle; master = requester, slave = client+memory
interface mem_requester_if import mem_req_pkg::*; #(
  parameter int addr_width = ADDR_W,
  parameter int data_width = DATA_W,
  parameter int len_width  = LEN_W
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [addr_width-1:0] req_addr;
  logic [data_width-1:0] req_wdata;
  logic [len_width-1:0]  req_len;
  logic                  mem_write;
  logic [addr_width-1:0] mem_addr;
  logic [data_width-1:0] mem_wdata;
  logic [data_width-1:0] mem_rdata;
  logic                  rsp_valid;
  logic [data_width-1:0] rsp_data;
  logic                  rsp_last;
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_len, mem_rdata,
    output req_ready, mem_write, mem_addr, mem_wdata, rsp_valid, rsp_data, rsp_last
  );
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_len, mem_rdata,
    input  req_ready, mem_write, mem_addr, mem_wdata, rsp_valid, rsp_data, rsp_last
  );
endinterface

// File: rtl/mem_requester.sv
// mem_requester: accepts single writes / incrementing read bursts and drives a 1-cycle-latency sync memory port
module mem_requester import mem_req_pkg::*; #(
  parameter int addr_width = ADDR_W,
  parameter int data_width = DATA_W,
  parameter int len_width  = LEN_W
) (
  input  logic clk,
  input  logic rst_n,
  mem_requester_if.master bus,
  output logic busy
);
  state_t                state_q;
  logic [len_width-1:0]  cnt_q, len_q;
  logic [addr_width-1:0] addr_q;
  logic [data_width-1:0] wdata_q;
  logic                  write_q, rsp_valid_q, rsp_last_q;
  logic                  last_beat, rd_issue;
  assign last_beat = cnt_q == len_q;
  // write_q doubles as the op flag while in ISSUE
  assign rd_issue  = state_q == ISSUE && !write_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
    end else begin
      // response stage mirrors the issue cycle one clock later, aligned with registered rdata
      rsp_valid_q <= rd_issue;
      rsp_last_q  <= rd_issue && last_beat;
      if (state_q == IDLE) begin
        if (bus.req_valid) begin
          state_q <= ISSUE;
          cnt_q   <= '0;
          len_q   <= bus.req_write ? '0 : bus.req_len;
          addr_q  <= bus.req_addr;
          wdata_q <= bus.req_wdata;
          write_q <= bus.req_write;
        end
      end else if (last_beat) begin
        state_q <= IDLE;
        write_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_q + 1'b1;
        addr_q <= addr_q + 1'b1;
      end
    end
  assign bus.req_ready = state_q == IDLE;
  assign bus.mem_write = write_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.rsp_data  = bus.mem_rdata;
  assign busy          = state_q == ISSUE || rsp_valid_q;
endmodule

// File: tb/tb_mem_requester.sv
// tb_mem_requester: directed self-checking bench with a sync single-port memory on the mem_* ports
module tb_mem_requester;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int checks = 0;
  int errors = 0;
  logic [7:0] mem [256];
  logic [7:0] rdata_q;
  mem_requester_if bus ();
  mem_requester dut (.clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
    rdata_q <= mem[bus.mem_addr];
  end
  assign bus.mem_rdata = rdata_q;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic req(input logic w, input logic [7:0] a, input logic [7:0] d, input logic [3:0] l);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_len   = l;
  endtask
  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    req(1'b1, a, d, 4'd0);
    tick();
    bus.req_valid = 1'b0;
    tick();
  endtask
  logic [7:0] wrap_addr [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
  logic [7:0] wrap_data [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_len   = '0;
    @(negedge clk);
    chk("rst_mem_write", bus.mem_write, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_req_ready", bus.req_ready, 1);
    // single write
    req(1'b1, 8'h10, 8'hA5, 4'd0);
    tick();
    bus.req_valid = 1'b0;
    chk("wr_mem_write_n1", bus.mem_write, 1);
    chk("wr_mem_addr", bus.mem_addr, 8'h10);
    chk("wr_mem_wdata", bus.mem_wdata, 8'hA5);
    chk("wr_req_ready_n1", bus.req_ready, 0);
    chk("wr_rsp_valid_n1", bus.rsp_valid, 0);
    tick();
    chk("wr_mem_write_n2", bus.mem_write, 0);
    chk("wr_req_ready_n2", bus.req_ready, 1);
    chk("wr_rsp_valid_n2", bus.rsp_valid, 0);
    // single read of the written location
    req(1'b0, 8'h10, 8'h00, 4'd0);
    tick();
    bus.req_valid = 1'b0;
    chk("rd1_mem_addr", bus.mem_addr, 8'h10);
    chk("rd1_rsp_valid_n1", bus.rsp_valid, 0);
    chk("rd1_busy_n1", busy, 1);
    tick();
    chk("rd1_rsp_valid_n2", bus.rsp_valid, 1);
    chk("rd1_rsp_data", bus.rsp_data, 8'hA5);
    chk("rd1_rsp_last", bus.rsp_last, 1);
    chk("rd1_busy_n2", busy, 1);
    tick();
    chk("rd1_busy_n3", busy, 0);
    chk("rd1_rsp_valid_n3", bus.rsp_valid, 0);
    // burst with address wrap
    do_write(8'hFE, 8'h01);
    do_write(8'hFF, 8'h02);
    do_write(8'h00, 8'h03);
    do_write(8'h01, 8'h04);
    req(1'b0, 8'hFE, 8'h00, 4'd3);
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) chk("wrap_mem_addr", bus.mem_addr, wrap_addr[i]);
      if (i > 0) begin
        chk("wrap_rsp_valid", bus.rsp_valid, 1);
        chk("wrap_rsp_data", bus.rsp_data, wrap_data[i-1]);
        chk("wrap_rsp_last", bus.rsp_last, i == 4);
      end
      tick();
    end
    chk("wrap_rsp_valid_end", bus.rsp_valid, 0);
    // back-to-back: write held on req_valid during the read's ISSUE phase
    do_write(8'h20, 8'h5A);
    do_write(8'h21, 8'h6B);
    req(1'b0, 8'h20, 8'h00, 4'd1);
    tick();
    req(1'b1, 8'h30, 8'h77, 4'd5);
    chk("b2b_ready_n1", bus.req_ready, 0);
    chk("b2b_addr_n1", bus.mem_addr, 8'h20);
    chk("b2b_write_n1", bus.mem_write, 0);
    tick();
    chk("b2b_ready_n2", bus.req_ready, 0);
    chk("b2b_addr_n2", bus.mem_addr, 8'h21);
    chk("b2b_rsp_valid_n2", bus.rsp_valid, 1);
    chk("b2b_rsp_data_n2", bus.rsp_data, 8'h5A);
    chk("b2b_rsp_last_n2", bus.rsp_last, 0);
    tick();
    chk("b2b_ready_n3", bus.req_ready, 1);
    chk("b2b_write_n3", bus.mem_write, 0);
    chk("b2b_rsp_valid_n3", bus.rsp_valid, 1);
    chk("b2b_rsp_data_n3", bus.rsp_data, 8'h6B);
    chk("b2b_rsp_last_n3", bus.rsp_last, 1);
    tick();
    bus.req_valid = 1'b0;
    chk("b2b_write_n4", bus.mem_write, 1);
    chk("b2b_waddr_n4", bus.mem_addr, 8'h30);
    chk("b2b_wdata_n4", bus.mem_wdata, 8'h77);
    chk("b2b_rsp_valid_n4", bus.rsp_valid, 0);
    tick();
    chk("b2b_write_n5", bus.mem_write, 0);
    chk("b2b_mem30", mem[8'h30], 8'h77);
    // reset during the third issue cycle of a long burst
    req(1'b0, 8'h40, 8'h00, 4'd7);
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    chk("mid_rsp_valid_pre", bus.rsp_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rsp_valid", bus.rsp_valid, 0);
    chk("mid_rsp_last", bus.rsp_last, 0);
    chk("mid_mem_write", bus.mem_write, 0);
    chk("mid_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_req_ready", bus.req_ready, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("mid_no_stray_rsp", bus.rsp_valid, 0);
    end
    // abandoned write
    req(1'b1, 8'h50, 8'h99, 4'd0);
    tick();
    bus.req_valid = 1'b0;
    chk("abw_mem_write_pre", bus.mem_write, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abw_mem_write", bus.mem_write, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    // maximum-length burst over 0x00..0x0F
    for (int i = 0; i < 16; i++) do_write(8'(i), 8'(i));
    req(1'b0, 8'h00, 8'h00, 4'd15);
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) chk("max_mem_addr", bus.mem_addr, i);
      if (i > 0) begin
        chk("max_rsp_valid", bus.rsp_valid, 1);
        chk("max_rsp_data", bus.rsp_data, i - 1);
        chk("max_rsp_last", bus.rsp_last, i == 16);
      end
      tick();
    end
    chk("max_rsp_valid_end", bus.rsp_valid, 0);
    chk("max_busy_end", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
